// File: rtl/sram_rw_arbiter.sv
// sram_rw_arbiter: request stage in front of a single-port 1RW SRAM.
// Merges a write channel and a read channel onto one RW port. Writes win by
// default; a read that keeps losing is forced through after STARVE_MAX cycles.
// Read data returns one cycle after the enable. It is either bypassed straight
// to the consumer or parked in a 2-entry FIFO. A credit check keeps at most
// two responses outstanding, so none is ever dropped.
//
// Handshake rule for every channel: a transfer happens in a cycle where valid
// and ready are both high. Ready never depends combinationally on its own
// channel's ready. Once valid is raised, the source holds it and its payload
// stable until the transfer happens.
//
// Optional build macro SRAM_ARB_STATS_EN adds the saturating fire/stall
// counters stat_rd, stat_wr and stat_stall.
module sram_rw_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int MASK_W     = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [MASK_W-1:0] wr_mask,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_rd,
  output logic [15:0]       stat_wr,
  output logic [15:0]       stat_stall
`endif
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  // Response FIFO bookkeeping and arbitration state
  logic [1:0]        cnt_q, cnt_d;
  logic              inflight_q, inflight_d;
  logic [3:0]        starve_q, starve_d;
  logic              head_q, head_d;
  logic              tail_q, tail_d;
  logic [DATA_W-1:0] buf_q [2];

  logic [2:0] occ;
  logic       rd_credit;
  logic       rd_fire;
  logic       wr_fire;
  logic       push;
  logic       pop;

  // Credit and arbitration; a saturated starve counter overrides write priority
  always_comb begin
    occ       = {1'b0, cnt_q} + {2'b00, inflight_q};
    rd_credit = (occ < 3'd2);
    rd_ready  = reset_n && rd_credit && (!wr_valid || (starve_q == STARVE_LIM));
    wr_ready  = reset_n && !(rd_valid && rd_ready);
    rd_fire   = rd_valid && rd_ready;
    wr_fire   = wr_valid && wr_ready;
  end

  // SRAM port drive in the accept cycle; idle drives all zeros
  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wmask = '0;
    sram_wdata = '0;
    if (wr_fire) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = wr_addr;
      sram_wmask = wr_mask;
      sram_wdata = wr_data;
    end else if (rd_fire) begin
      sram_en   = 1'b1;
      sram_addr = rd_addr;
    end
  end

  // Response path: bypass when the FIFO is empty, otherwise serve the head
  always_comb begin
    rsp_valid = reset_n && ((cnt_q != 2'd0) || inflight_q);
    rsp_data  = (cnt_q != 2'd0) ? buf_q[head_q] : sram_rdata;
    pop       = rsp_valid && rsp_ready && (cnt_q != 2'd0);
    push      = inflight_q && !((cnt_q == 2'd0) && rsp_ready);
  end

  // Next-state for occupancy, pointers, in-flight flag and starvation counter
  always_comb begin
    cnt_d      = cnt_q;
    head_d     = head_q;
    tail_d     = tail_q;
    inflight_d = rd_fire;
    starve_d   = starve_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    if (push) tail_d = ~tail_q;
    if (pop)  head_d = ~head_q;
    if (rd_fire) begin
      starve_d = 4'd0;
    end else if (rd_valid && rd_credit && wr_valid && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Control state register with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
      starve_q   <= 4'd0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      starve_q   <= starve_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // FIFO data storage; contents are only meaningful below cnt_q, so no reset
  always_ff @(posedge clock) begin
    if (push) begin
      buf_q[tail_q] <= sram_rdata;
    end
  end

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] stat_rd_q, stat_wr_q, stat_stall_q;
  logic        stall;

  // A read that has credit but is not accepted counts as a stall
  always_comb begin
    stall = rd_valid && rd_credit && !rd_ready;
  end

  // Saturating event counters
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stat_rd_q    <= 16'd0;
      stat_wr_q    <= 16'd0;
      stat_stall_q <= 16'd0;
    end else begin
      if (rd_fire && (stat_rd_q != 16'hFFFF)) stat_rd_q    <= stat_rd_q + 16'd1;
      if (wr_fire && (stat_wr_q != 16'hFFFF)) stat_wr_q    <= stat_wr_q + 16'd1;
      if (stall && (stat_stall_q != 16'hFFFF)) stat_stall_q <= stat_stall_q + 16'd1;
    end
  end

  assign stat_rd    = stat_rd_q;
  assign stat_wr    = stat_wr_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Testbench for sram_rw_arbiter with a behavioural 1-cycle-latency SRAM.
// Inputs change 1 time unit after the rising edge. Outputs are checked on the
// falling edge.
module tb_sram_rw_arbiter;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int MW = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_n;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [MW-1:0] wr_mask;
  logic          rd_valid, rd_ready;
  logic [AW-1:0] rd_addr;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] sram_addr;
  logic          sram_en, sram_wmode;
  logic [MW-1:0] sram_wmask;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
`ifdef SRAM_ARB_STATS_EN
  logic [15:0] stat_rd, stat_wr, stat_stall;
`endif

  sram_rw_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .STARVE_MAX(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_mask    (wr_mask),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_addr    (rd_addr),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .sram_addr  (sram_addr),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_wmask (sram_wmask),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
`ifdef SRAM_ARB_STATS_EN
    ,
    .stat_rd    (stat_rd),
    .stat_wr    (stat_wr),
    .stat_stall (stat_stall)
`endif
  );

  // Behavioural SRAM macro: byte-lane masked write, registered read data
  logic [DW-1:0] mem [64];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    sram_rdata = '0;
  end
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        for (int l = 0; l < MW; l++)
          if (sram_wmask[l]) mem[sram_addr][8*l +: 8] <= sram_wdata[8*l +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] shadow [64];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle(input logic rr);
    wr_valid  = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
    rd_valid  = 1'b0; rd_addr = '0;
    rsp_ready = rr;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          wv;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [MW-1:0] wm;
    logic          rv;
    logic [AW-1:0] ra;
    logic          rr;
    logic          e_wrdy;
    logic          e_rrdy;
    logic          e_en;
    logic          e_wmode;
    logic [AW-1:0] e_addr;
    logic [MW-1:0] e_wmask;
    logic          e_rspv;
    logic [DW-1:0] e_rspd;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  function automatic vec_t mk(logic wv, logic [AW-1:0] wa, logic [DW-1:0] wd, logic [MW-1:0] wm,
                              logic rv, logic [AW-1:0] ra, logic rr,
                              logic e_wrdy, logic e_rrdy, logic e_en, logic e_wmode,
                              logic [AW-1:0] e_addr, logic [MW-1:0] e_wmask,
                              logic e_rspv, logic [DW-1:0] e_rspd);
    vec_t v;
    v.wv = wv; v.wa = wa; v.wd = wd; v.wm = wm; v.rv = rv; v.ra = ra; v.rr = rr;
    v.e_wrdy = e_wrdy; v.e_rrdy = e_rrdy; v.e_en = e_en; v.e_wmode = e_wmode;
    v.e_addr = e_addr; v.e_wmask = e_wmask; v.e_rspv = e_rspv; v.e_rspd = e_rspd;
    return v;
  endfunction

  logic wf, rf;
  int   phase;

  initial begin
    //              wv wa  wd            wm    rv ra rr | wrdy rrdy en wm addr wmask rspv rspd
    tbl[0]  = mk(0, 0, 32'h0,        4'h0, 0, 0, 1,  1, 1, 0, 0, 0, 4'h0, 0, 32'h0);
    tbl[1]  = mk(1, 5, 32'hDEADBEEF, 4'hF, 0, 0, 1,  1, 0, 1, 1, 5, 4'hF, 0, 32'h0);
    tbl[2]  = mk(0, 0, 32'h0,        4'h0, 1, 5, 1,  0, 1, 1, 0, 5, 4'h0, 0, 32'h0);
    tbl[3]  = mk(0, 0, 32'h0,        4'h0, 0, 0, 1,  1, 1, 0, 0, 0, 4'h0, 1, 32'hDEADBEEF);
    tbl[4]  = mk(1, 7, 32'h11223344, 4'hF, 0, 0, 1,  1, 0, 1, 1, 7, 4'hF, 0, 32'h0);
    tbl[5]  = mk(1, 7, 32'h0000AB00, 4'h2, 0, 0, 1,  1, 0, 1, 1, 7, 4'h2, 0, 32'h0);
    tbl[6]  = mk(0, 0, 32'h0,        4'h0, 1, 7, 1,  0, 1, 1, 0, 7, 4'h0, 0, 32'h0);
    tbl[7]  = mk(0, 0, 32'h0,        4'h0, 0, 0, 1,  1, 1, 0, 0, 0, 4'h0, 1, 32'h1122AB44);
    tbl[8]  = mk(1, 0, 32'hA0A00000, 4'hF, 0, 0, 1,  1, 0, 1, 1, 0, 4'hF, 0, 32'h0);
    tbl[9]  = mk(1, 1, 32'hA1A11111, 4'hF, 0, 0, 1,  1, 0, 1, 1, 1, 4'hF, 0, 32'h0);
    tbl[10] = mk(1, 2, 32'hA2A22222, 4'hF, 0, 0, 1,  1, 0, 1, 1, 2, 4'hF, 0, 32'h0);
    tbl[11] = mk(1, 3, 32'hA3A33333, 4'hF, 0, 0, 1,  1, 0, 1, 1, 3, 4'hF, 0, 32'h0);
    tbl[12] = mk(0, 0, 32'h0,        4'h0, 1, 0, 0,  0, 1, 1, 0, 0, 4'h0, 0, 32'h0);
    tbl[13] = mk(0, 0, 32'h0,        4'h0, 1, 1, 0,  0, 1, 1, 0, 1, 4'h0, 1, 32'hA0A00000);
    tbl[14] = mk(0, 0, 32'h0,        4'h0, 1, 2, 0,  1, 0, 0, 0, 0, 4'h0, 1, 32'hA0A00000);
    tbl[15] = mk(1, 9, 32'h00000055, 4'hF, 1, 2, 0,  1, 0, 1, 1, 9, 4'hF, 1, 32'hA0A00000);
    tbl[16] = mk(0, 0, 32'h0,        4'h0, 1, 2, 1,  1, 0, 0, 0, 0, 4'h0, 1, 32'hA0A00000);
    tbl[17] = mk(0, 0, 32'h0,        4'h0, 1, 2, 1,  0, 1, 1, 0, 2, 4'h0, 1, 32'hA1A11111);
    tbl[18] = mk(0, 0, 32'h0,        4'h0, 1, 3, 1,  0, 1, 1, 0, 3, 4'h0, 1, 32'hA2A22222);
    tbl[19] = mk(0, 0, 32'h0,        4'h0, 0, 0, 1,  1, 1, 0, 0, 0, 4'h0, 1, 32'hA3A33333);
    tbl[20] = mk(0, 0, 32'h0,        4'h0, 0, 0, 1,  1, 1, 0, 0, 0, 4'h0, 0, 32'h0);

    for (int i = 0; i < 64; i++) shadow[i] = '0;

    // ---- reset with both channels requesting ----
    reset_n = 1'b0;
    set_idle(1'b1);
    wr_valid = 1'b1; wr_addr = 6'd1; wr_data = 32'h1; wr_mask = 4'hF;
    rd_valid = 1'b1; rd_addr = 6'd1;
    next_cycle();
    @(negedge clock);
    chk("rst wr_ready", 32'(wr_ready), 32'd0);
    chk("rst rd_ready", 32'(rd_ready), 32'd0);
    chk("rst sram_en", 32'(sram_en), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    next_cycle();
    reset_n = 1'b1;
    set_idle(1'b1);
`ifdef SRAM_ARB_STATS_EN
    @(negedge clock);
    chk("rst stat_rd", 32'(stat_rd), 32'd0);
    chk("rst stat_wr", 32'(stat_wr), 32'd0);
    chk("rst stat_stall", 32'(stat_stall), 32'd0);
    next_cycle();
`endif

    // ---- table-driven directed sequence ----
    for (int i = 0; i < NV; i++) begin
      wr_valid = tbl[i].wv; wr_addr = tbl[i].wa; wr_data = tbl[i].wd; wr_mask = tbl[i].wm;
      rd_valid = tbl[i].rv; rd_addr = tbl[i].ra; rsp_ready = tbl[i].rr;
      @(negedge clock);
      chk($sformatf("v%0d wr_ready", i), 32'(wr_ready), 32'(tbl[i].e_wrdy));
      chk($sformatf("v%0d rd_ready", i), 32'(rd_ready), 32'(tbl[i].e_rrdy));
      chk($sformatf("v%0d sram_en", i), 32'(sram_en), 32'(tbl[i].e_en));
      chk($sformatf("v%0d sram_wmode", i), 32'(sram_wmode), 32'(tbl[i].e_wmode));
      chk($sformatf("v%0d sram_wmask", i), 32'(sram_wmask), 32'(tbl[i].e_wmask));
      if (tbl[i].e_en) chk($sformatf("v%0d sram_addr", i), 32'(sram_addr), 32'(tbl[i].e_addr));
      chk($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].e_rspv));
      if (tbl[i].e_rspv) chk($sformatf("v%0d rsp_data", i), rsp_data, tbl[i].e_rspd);
      next_cycle();
    end

    // ---- starvation: write held high, read forced through on the 5th cycle ----
    set_idle(1'b1);
    wr_valid = 1'b1; wr_addr = 6'd10; wr_data = 32'hCAFE0010; wr_mask = 4'hF;
    rd_valid = 1'b1; rd_addr = 6'd10;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      chk($sformatf("starve c%0d rd_ready", c), 32'(rd_ready), 32'd0);
      chk($sformatf("starve c%0d wr_ready", c), 32'(wr_ready), 32'd1);
      next_cycle();
    end
    @(negedge clock);
    chk("starve c5 rd_ready", 32'(rd_ready), 32'd1);
    chk("starve c5 wr_ready", 32'(wr_ready), 32'd0);
    chk("starve c5 sram_wmode", 32'(sram_wmode), 32'd0);
`ifdef SRAM_ARB_STATS_EN
    chk("starve stat_stall", 32'(stat_stall), 32'd4);
`endif
    next_cycle();
    rd_valid = 1'b0;
    @(negedge clock);
    chk("starve c6 wr_ready", 32'(wr_ready), 32'd1);
    chk("starve c6 rsp_valid", 32'(rsp_valid), 32'd1);
    chk("starve c6 rsp_data", rsp_data, 32'hCAFE0010);
    next_cycle();
    set_idle(1'b1);
    next_cycle();

    // ---- reset while a read is in flight ----
    rd_valid = 1'b1; rd_addr = 6'd5; rsp_ready = 1'b0;
    @(negedge clock);
    chk("rstfl accept", 32'(rd_ready), 32'd1);
    next_cycle();
    reset_n = 1'b0;
    wr_valid = 1'b1; wr_addr = 6'd5; wr_data = 32'h0BAD0BAD; wr_mask = 4'hF;
    rd_valid = 1'b1;
    @(negedge clock);
    chk("rstfl wr_ready", 32'(wr_ready), 32'd0);
    chk("rstfl rd_ready", 32'(rd_ready), 32'd0);
    chk("rstfl sram_en", 32'(sram_en), 32'd0);
    chk("rstfl rsp_valid", 32'(rsp_valid), 32'd0);
    next_cycle();
    reset_n = 1'b1;
    set_idle(1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk($sformatf("rstfl stale c%0d", c), 32'(rsp_valid), 32'd0);
      next_cycle();
    end
    rd_valid = 1'b1; rd_addr = 6'd5;
    @(negedge clock);
    chk("rstfl reread accept", 32'(rd_ready), 32'd1);
    next_cycle();
    set_idle(1'b1);
    @(negedge clock);
    chk("rstfl reread rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rstfl reread rsp_data", rsp_data, 32'hDEADBEEF);
    next_cycle();
    @(negedge clock);
    chk("rstfl after rsp_valid", 32'(rsp_valid), 32'd0);
    next_cycle();

    // ---- alternating read/write traffic with random consumer backpressure ----
    exp_q.delete();
    phase = 0;
    for (int c = 0; c < 110; c++) begin
      if (c < 100) begin
        if (phase == 0 && !rd_valid) begin
          rd_valid = 1'b1; rd_addr = 6'($urandom_range(16, 31));
        end
        if (phase == 1 && !wr_valid) begin
          wr_valid = 1'b1; wr_addr = 6'($urandom_range(16, 31));
          wr_data = $urandom; wr_mask = 4'hF;
        end
        phase = 1 - phase;
        rsp_ready = 1'($urandom_range(0, 1));
      end else begin
        rsp_ready = 1'b1;
      end
      @(negedge clock);
      wf = wr_valid && wr_ready;
      rf = rd_valid && rd_ready;
      chk($sformatf("alt c%0d port", c), {29'd0, sram_en, sram_wmode, wf && rf},
          {29'd0, wf || rf, wf, 1'b0});
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("alt c%0d dup rsp", c), 32'd1, 32'd0);
        end else begin
          chk($sformatf("alt c%0d rsp_data", c), rsp_data, exp_q.pop_front());
        end
      end
      if (wf) shadow[wr_addr] = wr_data;
      if (rf) exp_q.push_back(shadow[rd_addr]);
      next_cycle();
      if (wf) wr_valid = 1'b0;
      if (rf) rd_valid = 1'b0;
    end
    chk("alt outstanding", 32'(exp_q.size()), 32'd0);
    chk("alt pending req", {30'd0, wr_valid, rd_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_rw_arbiter.md
Name: sram_rw_arbiter

Overview:
- Upstream request stage for a single-port 1RW SRAM wrapper, such as the data-array wrappers.
- Merges an independent write channel and an independent read channel (valid/ready) onto the single RW port (addr/en/wmode/wmask/wdata).
- Captures the 1-cycle-latency rdata into a 2-entry response buffer with backpressure, so cache-side logic never has to handle the macro timing.

Parameters:
- ADDR_W, 6, SRAM address width
- DATA_W, 32, data width
- MASK_W, 4, write-mask width; each bit covers DATA_W/MASK_W bits
- STARVE_MAX, 4, max consecutive cycles an eligible read may lose to writes (range 1..15)

Ports:
- clock  in  1  sole clock, all state on rising edge
- reset_n  in  1  synchronous, active-low reset
- wr_valid  in  1  write request valid
- wr_ready  out  1  write request accepted this cycle
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_mask  in  MASK_W  write byte-lane mask
- rd_valid  in  1  read request valid
- rd_ready  out  1  read request accepted this cycle
- rd_addr  in  ADDR_W  read address
- rsp_valid  out  1  read response valid
- rsp_ready  in  1  response consumer ready
- rsp_data  out  DATA_W  read response data
- sram_addr  out  ADDR_W  to SRAM RW0_addr
- sram_en  out  1  to SRAM RW0_en
- sram_wmode  out  1  to SRAM RW0_wmode (1 = write)
- sram_wmask  out  MASK_W  to SRAM RW0_wmask
- sram_wdata  out  DATA_W  to SRAM RW0_wdata
- sram_rdata  in  DATA_W  from SRAM RW0_rdata, valid the cycle after a read enable

Behaviour:
- State:
  - cnt: response-buffer occupancy, 0..2.
  - inflight: 1 bit, read issued last cycle.
  - starve: counter, 0..STARVE_MAX.
- Credit: rd_credit = (cnt + inflight) < 2.
- Arbitration, combinational:
  - rd_ready = reset_n && rd_credit && (!wr_valid || starve == STARVE_MAX).
  - wr_ready = reset_n && !(rd_valid && rd_ready).
  - Writes win by default. A read wins when no write is pending or when starve has saturated.
  - No combinational path exists from wr_ready/rd_ready back to valids.
- SRAM drive, combinational, same cycle as the accept:
  - Write fire: sram_en=1, sram_wmode=1, addr=wr_addr, wmask=wr_mask, wdata=wr_data.
  - Read fire: sram_en=1, sram_wmode=0, addr=rd_addr, wmask=0, wdata=0.
  - Idle or in reset: all sram_* outputs 0.
- Starve counter:
  - Increments (saturating) each cycle rd_valid && rd_credit && wr_valid && !rd_ready.
  - Clears on a read fire.
  - Holds otherwise.
- Response path:
  - inflight <= read fire.
  - If inflight and cnt==0: rsp_valid=1 and rsp_data=sram_rdata (bypass). If also rsp_ready, nothing is stored.
  - If inflight and the bypass is not consumed (or cnt>0): sram_rdata is pushed at the tail.
  - If cnt>0: rsp_valid=1 and rsp_data=head entry. rsp_ready pops the head.
  - Push and pop in the same cycle leave cnt unchanged; order is strictly FIFO.
- Latency: a read accepted in cycle N presents rsp_valid in N+1 at the earliest. Sustained throughput is 1 read/cycle with rsp_ready held high.
- Ordering: reads and writes hit the SRAM in accept order. A read accepted after a write to the same address returns the new data; no forwarding logic is needed.
- Boundaries:
  - Credit exhausted (cnt+inflight==2): rd_ready=0, and writes still proceed.
  - rsp_ready low indefinitely: at most 2 responses are held and none are dropped.
  - STARVE_MAX reached with a write pending: the read is granted, wr_ready=0 for that cycle, and the write stalls exactly one cycle.
- Reset (reset_n low at a clock edge):
  - cnt=0, inflight=0, starve=0, rsp_valid=0.
  - While reset_n is low: wr_ready=0, rd_ready=0, sram_en=0.
  - A read in flight when reset asserts is discarded; no response appears after release.

Optional Feature:
- Macro: SRAM_ARB_STATS_EN.
- With the macro: adds outputs stat_rd[15:0], stat_wr[15:0] and stat_stall[15:0].
  - stat_rd and stat_wr count read and write fires.
  - stat_stall counts cycles where rd_valid && rd_credit && !rd_ready.
  - All three saturate at 16'hFFFF and are cleared by reset.
- Without the macro: these ports and their counters do not exist; behaviour is otherwise identical.

Test Plan:
- Write addr 5, data 32'hDEADBEEF, mask 4'hF. Next cycle read addr 5 with rsp_ready=1 → sram_en/wmode=1/1 then 1/0; rsp_valid one cycle after the read accept with rsp_data=32'hDEADBEEF.
- Issue 4 back-to-back reads (addr 0..3) with rsp_ready=0 → only 2 accepted, rd_ready=0 afterwards. Raise rsp_ready → data for addr 0 then 1 in order, then the remaining reads are accepted.
- wr_valid held high continuously with rd_valid high, STARVE_MAX=4 → read granted on the 5th cycle; wr_ready=0 only in that cycle; stat_stall=4 when SRAM_ARB_STATS_EN is defined.
- Partial write mask 4'b0010 with data 32'h0000AB00 over the existing 32'h11223344 → read returns 32'h1122AB44.
- Read accepted, then reset_n low for 1 cycle → rsp_valid=0 after reset, cnt=0, no stale response; a subsequent read works normally.
- Alternating read/write every cycle for 100 cycles with random rsp_ready → no lost or duplicated responses; SRAM never sees en with both a read and a write in the same cycle.
